cnn_relu_maxpool: RTL and testbench
===================================

// Module: cnn_relu_maxpool
// PURPOSE
//  Post-processing stage directly downstream of the CNN top core.
//  Captures one full output-fmap batch on a valid pulse, then walks it sequentially:
//  - applies ReLU
//  - applies 2x2 stride-2 max pooling
//  Presents the pooled batch with a valid/ready handshake to the next layer/readout.
// PARAMETERS
//  IN        2   batch size (fmaps per transfer)
//  OCH       3   channels per fmap
//  OX        4   input fmap width; must be even
//  OY        4   input fmap height; must be even
//  DATA_LEN  32  element width, signed two's complement
//  Derived:
//   PX   = OX/2
//   PY   = OY/2
//   NOUT = IN*OCH*PX*PY   (default 24)
// PORTS
//  clk         in   1                     clock
//  reset       in   1                     synchronous, active-high reset
//  i_in_valid  in   1                     single-cycle pulse, fmap batch present
//  i_in_fmap   in   IN*OCH*OX*OY*DATA_LEN input batch
//  o_in_ready  out  1                     block can accept a batch this cycle
//  o_drop      out  1                     one-cycle pulse, i_in_valid seen while not ready
//  o_ot_valid  out  1                     pooled batch valid, held until accepted
//  i_ot_ready  in   1                     downstream accepts pooled batch
//  o_ot_fmap   out  IN*OCH*PX*PY*DATA_LEN pooled batch
// BEHAVIOUR
//  Packing (LSB first, both buses):
//   - input element  ((n*OCH+c)*OY+y)*OX+x  at [idx*DATA_LEN +: DATA_LEN]
//   - output element ((n*OCH+c)*PY+py)*PX+px
//  Reset (sync, high): state=IDLE, counter=0, o_ot_fmap=0, o_ot_valid=0, o_drop=0.
//   - Reset asserted mid-RUN or mid-DONE aborts the batch; no partial output is ever flagged valid.
//  FSM:
//   IDLE: o_in_ready=1.
//    - i_in_valid -> latch i_in_fmap into input buffer, cnt=0, go RUN.
//   RUN: one output element per cycle, index cnt.
//    - v = max of the 4 signed inputs at (2py..2py+1, 2px..2px+1).
//    - o_ot_fmap[cnt] = (v<0) ? 0 : v. ReLU applied after max; equivalent result.
//    - cnt++; after element NOUT-1 is written, go DONE.
//    - o_in_ready=0.
//   DONE: o_ot_valid=1; o_ot_fmap stable.
//    - i_ot_ready=1 and i_in_valid=0 -> IDLE.
//    - i_ot_ready=1 and i_in_valid=1 -> latch new batch, go RUN; back-to-back, no bubble.
//    - i_ot_ready=0 -> stay in DONE.
//    - o_in_ready = i_ot_ready (combinational, DONE only).
//  Latency: batch accepted at edge T -> o_ot_valid first high in the cycle after edge T+NOUT.
//  Throughput: one batch per NOUT+1 cycles when i_ot_ready is tied high.
//  Drop: i_in_valid while o_in_ready=0 -> batch discarded, o_drop=1 for the next cycle.
//   - Buffer and state unaffected.
//  o_ot_fmap holds its last value from DONE exit until RUN overwrites it.
//   - Consumers sample it only while o_ot_valid=1.
//  Arithmetic: comparisons are signed over the full DATA_LEN; no truncation or saturation.
// TESTING
//  T1 All-positive ramp: batch element value = idx (0..95), valid pulse, i_ot_ready=1.
//     -> o_ot_valid after 25 cycles.
//     -> pooled[0] = 5, pooled[1] = 7, pooled[2] = 13, pooled[3] = 15, continuing per channel.
//  T2 All-negative batch (every element = -7).
//     -> all 24 outputs = 0, o_ot_valid=1.
//  T3 Mixed signs in one window {-1, -100, 3, -2}.
//     -> 3; window {-5, -4, -3, -2} -> 0; window {0x7FFFFFFF, ...} -> 0x7FFFFFFF.
//  T4 Backpressure: hold i_ot_ready=0 for 10 cycles in DONE.
//     -> o_ot_valid and o_ot_fmap stable throughout.
//     -> second i_in_valid pulse in that window gives o_drop=1 and output unchanged.
//  T5 Back-to-back: i_in_valid coincident with i_ot_ready in DONE.
//     -> second batch accepted with no idle cycle.
//     -> second o_ot_valid exactly 25 cycles later.
//  T6 reset pulse at RUN cycle 10.
//     -> next cycle o_ot_valid=0, o_in_ready=1, o_ot_fmap=0.
//     -> fresh batch then completes correctly.

Source files
------------

// File: rtl/cnn_relu_maxpool.sv
// ReLU + 2x2 stride-2 max-pool stage: captures one fmap batch, emits one pooled element per
// cycle, then holds the pooled batch under a valid/ready handshake.
module cnn_relu_maxpool #(
    parameter int unsigned IN       = 2,
    parameter int unsigned OCH      = 3,
    parameter int unsigned OX       = 4,
    parameter int unsigned OY       = 4,
    parameter int unsigned DATA_LEN = 32
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       i_in_valid,
    input  logic [IN*OCH*OX*OY*DATA_LEN-1:0]           i_in_fmap,
    output logic                                       o_in_ready,
    output logic                                       o_drop,
    output logic                                       o_ot_valid,
    input  logic                                       i_ot_ready,
    output logic [IN*OCH*(OX/2)*(OY/2)*DATA_LEN-1:0]   o_ot_fmap
);

    localparam int unsigned PX    = OX / 2;
    localparam int unsigned PY    = OY / 2;
    localparam int unsigned NIN   = IN * OCH * OX * OY;
    localparam int unsigned NOUT  = IN * OCH * PX * PY;
    localparam int unsigned InAW  = (NIN > 1) ? $clog2(NIN) : 1;
    localparam int unsigned OutAW = (NOUT > 1) ? $clog2(NOUT) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                      state_q, state_d;
    logic [OutAW-1:0]            cnt_q, cnt_d;
    logic signed [DATA_LEN-1:0]  buf_q [NIN];
    logic signed [DATA_LEN-1:0]  buf_d [NIN];
    logic signed [DATA_LEN-1:0]  out_q [NOUT];
    logic signed [DATA_LEN-1:0]  out_d [NOUT];
    logic signed [DATA_LEN-1:0]  in_words [NIN];
    logic                        valid_q, valid_d;
    logic                        drop_q, drop_d;

    int unsigned                 cnt_u, base;
    logic [InAW-1:0]             i00, i01, i10, i11;
    logic signed [DATA_LEN-1:0]  m_top, m_bot, max_v, relu_v;

    for (genvar g = 0; g < NIN; g++) begin : g_unpack
        assign in_words[g] = i_in_fmap[g*DATA_LEN +: DATA_LEN];
    end

    for (genvar g = 0; g < NOUT; g++) begin : g_pack
        assign o_ot_fmap[g*DATA_LEN +: DATA_LEN] = out_q[g];
    end

    // Top-left corner of the pooling window addressed by cnt_q.
    always_comb begin
        cnt_u  = 32'(cnt_q);
        base   = ((cnt_u / (PX * PY)) * OY + 2 * ((cnt_u / PX) % PY)) * OX + 2 * (cnt_u % PX);
        i00    = InAW'(base);
        i01    = InAW'(base + 1);
        i10    = InAW'(base + OX);
        i11    = InAW'(base + OX + 1);
        m_top  = (buf_q[i00] > buf_q[i01]) ? buf_q[i00] : buf_q[i01];
        m_bot  = (buf_q[i10] > buf_q[i11]) ? buf_q[i10] : buf_q[i11];
        max_v  = (m_top > m_bot) ? m_top : m_bot;
        relu_v = max_v[DATA_LEN-1] ? '0 : max_v;
    end

    assign o_in_ready = (state_q == StIdle) || ((state_q == StDone) && i_ot_ready);
    assign o_ot_valid = valid_q;
    assign o_drop     = drop_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        out_d   = out_q;
        valid_d = valid_q;
        drop_d  = i_in_valid && !o_in_ready;
        unique case (state_q)
            StIdle: begin
                if (i_in_valid) begin
                    buf_d   = in_words;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                out_d[cnt_q] = relu_v;
                cnt_d        = cnt_q + OutAW'(1);
                if (cnt_u == NOUT - 1) begin
                    state_d = StDone;
                    valid_d = 1'b1;
                end
            end
            StDone: begin
                if (i_ot_ready) begin
                    valid_d = 1'b0;
                    if (i_in_valid) begin
                        buf_d   = in_words;
                        cnt_d   = '0;
                        state_d = StRun;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            buf_q   <= '{default: '0};
            out_q   <= '{default: '0};
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_cnn_relu_maxpool.sv
// Scoreboard bench for cnn_relu_maxpool: a loop-based pooling model queues expected batches,
// a monitor pops them on every output handshake and checks valid-rise latency.
module tb_cnn_relu_maxpool;

    localparam int IN = 2, OCH = 3, OX = 4, OY = 4, DL = 32;
    localparam int PX = OX / 2, PY = OY / 2;
    localparam int NIN = IN * OCH * OX * OY;
    localparam int NOUT = IN * OCH * PX * PY;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 i_in_valid = 1'b0;
    logic                 i_ot_ready = 1'b1;
    logic [NIN*DL-1:0]    i_in_fmap;
    logic [NOUT*DL-1:0]   o_ot_fmap;
    logic                 o_in_ready, o_drop, o_ot_valid;

    int in_arr [NIN];
    int out_arr [NOUT];
    int snap [NOUT];
    int exp_q [$];
    int lat_q [$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic prev_v = 1'b0;

    for (genvar g = 0; g < NIN; g++) begin : g_in
        assign i_in_fmap[g*DL +: DL] = in_arr[g];
    end
    for (genvar g = 0; g < NOUT; g++) begin : g_out
        assign out_arr[g] = o_ot_fmap[g*DL +: DL];
    end

    cnn_relu_maxpool #(.IN(IN), .OCH(OCH), .OX(OX), .OY(OY), .DATA_LEN(DL)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_in_valid (i_in_valid),
        .i_in_fmap  (i_in_fmap),
        .o_in_ready (o_in_ready),
        .o_drop     (o_drop),
        .o_ot_valid (o_ot_valid),
        .i_ot_ready (i_ot_ready),
        .o_ot_fmap  (o_ot_fmap)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: nested loops over the output grid, max of each 2x2 window, then clamp at 0.
    task automatic model();
        for (int n = 0; n < IN; n++)
            for (int c = 0; c < OCH; c++)
                for (int py = 0; py < PY; py++)
                    for (int px = 0; px < PX; px++) begin
                        int b, m;
                        b = ((n * OCH + c) * OY + 2 * py) * OX + 2 * px;
                        m = in_arr[b];
                        if (in_arr[b + 1] > m) m = in_arr[b + 1];
                        if (in_arr[b + OX] > m) m = in_arr[b + OX];
                        if (in_arr[b + OX + 1] > m) m = in_arr[b + OX + 1];
                        if (m < 0) m = 0;
                        exp_q.push_back(m);
                    end
    endtask

    task automatic send(input bit exp_acc);
        bit acc;
        int acc_cyc;
        @(posedge clk); #1;
        i_in_valid = 1'b1;
        @(negedge clk);
        acc = o_in_ready;
        acc_cyc = cyc + 1;
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        chk("accept", int'(acc), int'(exp_acc));
        if (acc) begin
            model();
            lat_q.push_back(acc_cyc + NOUT);
        end
        @(negedge clk);
        chk("drop", int'(o_drop), int'(!acc));
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || lat_q.size() != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", exp_q.size() + lat_q.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        int nz = 0;
        @(negedge clk);
        chk({tag, "_valid"}, int'(o_ot_valid), 0);
        chk({tag, "_in_ready"}, int'(o_in_ready), 1);
        chk({tag, "_drop"}, int'(o_drop), 0);
        for (int i = 0; i < NOUT; i++) if (out_arr[i] != 0) nz++;
        chk({tag, "_fmap_nonzero"}, nz, 0);
    endtask

    // Monitor: latency on each valid rise, contents on each handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (o_ot_valid && !prev_v) begin
                if (lat_q.size() == 0) chk("unexpected_valid", 1, 0);
                else chk("latency", cyc, lat_q.pop_front());
            end
            if (o_ot_valid && i_ot_ready) begin
                if (exp_q.size() < NOUT) chk("unexpected_output", 1, 0);
                else for (int i = 0; i < NOUT; i++) chk("pooled", out_arr[i], exp_q.pop_front());
            end
        end
        prev_v <= o_ot_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NIN; i++) in_arr[i] = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_state("reset");

        // T1 ramp
        for (int i = 0; i < NIN; i++) in_arr[i] = i;
        send(1);
        drain();

        // T2 all negative
        for (int i = 0; i < NIN; i++) in_arr[i] = -7;
        send(1);
        drain();

        // T3 mixed-sign windows on top of small random values
        for (int i = 0; i < NIN; i++) in_arr[i] = int'($urandom_range(0, 20)) - 10;
        in_arr[0] = -1;  in_arr[1] = -100; in_arr[4] = 3;  in_arr[5] = -2;
        in_arr[2] = -5;  in_arr[3] = -4;   in_arr[6] = -3; in_arr[7] = -2;
        in_arr[8] = 32'h7FFF_FFFF; in_arr[9] = -1; in_arr[12] = 32'h8000_0000;
        send(1);
        drain();

        // Random full-range batches with random backpressure
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NIN; i++) in_arr[i] = int'($urandom);
            i_ot_ready = ($urandom_range(0, 1) == 1);
            send(1);
            repeat (NOUT + $urandom_range(2, 6)) @(posedge clk);
            #1 i_ot_ready = 1'b1;
            drain();
        end

        // T4 backpressure with drops in RUN and in DONE
        i_ot_ready = 1'b0;
        for (int i = 0; i < NIN; i++) in_arr[i] = int'($urandom_range(0, 1000)) - 500;
        send(1);
        send(0);
        begin
            int k = 0;
            while (!o_ot_valid && k < 100) begin
                @(negedge clk);
                k++;
            end
            chk("wait_valid", int'(o_ot_valid), 1);
        end
        for (int i = 0; i < NOUT; i++) snap[i] = out_arr[i];
        for (int h = 0; h < 10; h++) begin
            int diffs = 0;
            if (h == 4) begin
                for (int i = 0; i < NIN; i++) in_arr[i] = int'($urandom);
                send(0);
            end
            @(negedge clk);
            for (int i = 0; i < NOUT; i++) if (out_arr[i] != snap[i]) diffs++;
            chk("hold_valid", int'(o_ot_valid), 1);
            chk("hold_fmap_diffs", diffs, 0);
        end
        @(posedge clk); #1 i_ot_ready = 1'b1;
        drain();

        // T5 back-to-back: second pulse lands in the single DONE cycle
        for (int i = 0; i < NIN; i++) in_arr[i] = int'($urandom);
        send(1);
        repeat (NOUT - 1) @(posedge clk);
        for (int i = 0; i < NIN; i++) in_arr[i] = int'($urandom);
        send(1);
        drain();

        // T6 reset in the middle of RUN
        for (int i = 0; i < NIN; i++) in_arr[i] = int'($urandom);
        send(1);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        lat_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        check_reset_state("abort");
        for (int i = 0; i < NIN; i++) in_arr[i] = int'($urandom_range(0, 200)) - 100;
        send(1);
        drain();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
